// File: rtl/zuc_pkg.sv
// Shared types and constants for the ZUC LFSR state stage: cell type,
// sequencing states, the initialisation round count and the D load constants.
package zuc_pkg;

   // Number of initialisation-mode shifts before the single discard shift.
   localparam int ZUC_INIT_ROUNDS = 32;

   // One LFSR cell is an element of GF(2^31 - 1), held as 31 raw bits.
   typedef logic [30:0] zuc_cell_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_INIT    = 2'd1,
      ST_DISCARD = 2'd2,
      ST_RUN     = 2'd3
   } zuc_state_e;

   // 15-bit D constants placed between key byte and IV byte of each cell.
   localparam logic [14:0] ZUC_D [16] = '{
      15'h44D7, 15'h26BC, 15'h626B, 15'h135E,
      15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
      15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1,
      15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
   };

   // Load value of cell idx: {k_idx, D_idx, iv_idx}, byte 0 being the MSB.
   function automatic zuc_cell_t zuc_load_cell(input logic [127:0] key,
                                               input logic [127:0] iv,
                                               input int           idx);
      return {key[127 - 8*idx -: 8], ZUC_D[idx], iv[127 - 8*idx -: 8]};
   endfunction

endpackage

// File: rtl/zuc_bit_reorg.sv
// Bit reorganisation layer: builds X0..X3 from the high half H = [30:15]
// and low half L = [15:0] of selected LFSR cells. Pure combinational.
module zuc_bit_reorg
   import zuc_pkg::*;
(
   input  logic [30:0] s15_i,
   input  logic [30:0] s14_i,
   input  logic [30:0] s11_i,
   input  logic [30:0] s9_i,
   input  logic [30:0] s7_i,
   input  logic [30:0] s5_i,
   input  logic [30:0] s2_i,
   input  logic [30:0] s0_i,
   output logic [31:0] x0_o,
   output logic [31:0] x1_o,
   output logic [31:0] x2_o,
   output logic [31:0] x3_o
);

   // H and L overlap on bit 15, so each word takes exactly 32 of the 62 bits
   // in its two source cells.
   assign x0_o = {s15_i[30:15], s14_i[15:0]};
   assign x1_o = {s11_i[15:0],  s9_i[30:15]};
   assign x2_o = {s7_i[15:0],   s5_i[30:15]};
   assign x3_o = {s2_i[15:0],   s0_i[30:15]};

   // Bits of each cell that the reorganisation does not select.
   logic unused_bits;
   assign unused_bits = ^{s15_i[14:0], s14_i[30:16], s11_i[30:16], s9_i[14:0],
                          s7_i[30:16],  s5_i[14:0],  s2_i[30:16],  s0_i[14:0]};

endmodule

// File: rtl/zuc_lfsr_state.sv
// ZUC LFSR register file and phase sequencer. Holds cells s0..s15, loads
// them from key/IV, steps through INIT (32 shifts), DISCARD (1 shift) and
// RUN (one shift per consumed keystream word), and presents feedback taps,
// the reorganised X words and the FSM-stage update strobe.
module zuc_lfsr_state
   import zuc_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   input  logic [31:0]  w_in,
   input  logic [30:0]  s16_in,
   output logic [30:0]  s0,
   output logic [30:0]  s4,
   output logic [30:0]  s10,
   output logic [30:0]  s13,
   output logic [30:0]  s15,
   output logic         lfsr_mode,
   output logic [30:0]  u,
   output logic [31:0]  x0,
   output logic [31:0]  x1,
   output logic [31:0]  x2,
   output logic [31:0]  x3,
   output logic         fsm_step,
   output logic         busy,
   output logic         ks_valid,
   input  logic         ks_ready
);

   localparam logic [4:0] LAST_ROUND = 5'(ZUC_INIT_ROUNDS - 1);

   zuc_state_e state_q, state_d;
   logic [4:0] round_q, round_d;
   zuc_cell_t  cells_q [16];
   zuc_cell_t  cells_d [16];
   logic       load;
   logic       shift;

   // Phase sequencing: decides load/shift for this edge and drives the
   // per-phase strobes.
   always_comb begin
      // NOTE: every output of this block is given a default first so that no
      // path through the case leaves a signal unassigned and infers a latch.
      state_d   = state_q;
      round_d   = round_q;
      load      = 1'b0;
      shift     = 1'b0;
      lfsr_mode = 1'b0;
      fsm_step  = 1'b0;
      busy      = 1'b0;
      ks_valid  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               round_d = '0;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            // start is deliberately ignored until the keystream is running.
            lfsr_mode = 1'b1;
            fsm_step  = 1'b1;
            busy      = 1'b1;
            shift     = 1'b1;
            round_d   = round_q + 5'd1;
            if (round_q == LAST_ROUND) begin
               state_d = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            fsm_step = 1'b1;
            busy     = 1'b1;
            shift    = 1'b1;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            ks_valid = 1'b1;
            // The strobe follows ks_ready alone so that start never reaches it
            // combinationally; on a reload the FSM stage is reseeded anyway.
            fsm_step = ks_ready;
            if (start) begin
               load    = 1'b1;
               round_d = '0;
               state_d = ST_INIT;
            end else if (ks_ready) begin
               shift = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Next cell contents: fresh key/IV load, one-place shift, or hold.
   always_comb begin
      cells_d = cells_q;
      if (load) begin
         for (int i = 0; i < 16; i++) begin
            cells_d[i] = zuc_load_cell(key, iv, i);
         end
      end else if (shift) begin
         for (int i = 0; i < 15; i++) begin
            cells_d[i] = cells_q[i + 1];
         end
         // s16 arrives already reduced mod 2^31 - 1; it is stored as is.
         cells_d[15] = s16_in;
      end
   end

   // State, round counter and cell registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         // NOTE: the cell array is reset too, so an aborted run can never
         // leave key-derived material visible on the taps or X words.
         for (int i = 0; i < 16; i++) begin
            cells_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments give every register its
         // pre-edge value to read, which is what makes the shift correct.
         state_q <= state_d;
         round_q <= round_d;
         for (int i = 0; i < 16; i++) begin
            cells_q[i] <= cells_d[i];
         end
      end
   end

   // Feedback taps come straight from the registers.
   assign s0  = cells_q[0];
   assign s4  = cells_q[4];
   assign s10 = cells_q[10];
   assign s13 = cells_q[13];
   assign s15 = cells_q[15];

   // u = W >> 1 only while the feedback stage runs in initialisation mode.
   assign u = lfsr_mode ? w_in[31:1] : '0;

   // The LSB of W does not enter the feedback path.
   logic unused_w_in_lsb;
   assign unused_w_in_lsb = w_in[0];

   zuc_bit_reorg u_bit_reorg (
      .s15_i (cells_q[15]),
      .s14_i (cells_q[14]),
      .s11_i (cells_q[11]),
      .s9_i  (cells_q[9]),
      .s7_i  (cells_q[7]),
      .s5_i  (cells_q[5]),
      .s2_i  (cells_q[2]),
      .s0_i  (cells_q[0]),
      .x0_o  (x0),
      .x1_o  (x1),
      .x2_o  (x2),
      .x3_o  (x3)
   );

endmodule
